// File: rtl/pwm_update_sched.sv
// SPI command decoder with per-channel shadow registers and wrap-aligned commit sweep to the PWM bank.
// Optional broadcast write to address 7 is enabled by defining PWM_SCHED_BCAST_EN.
module pwm_update_sched #(
  parameter int NCH = 7
) (
  input  logic           sys_clk,
  input  logic           rst,
  input  logic [7:0]     byte_in,
  input  logic           byte_valid,
  input  logic           frame_abort,
  input  logic           counter_wrap,
  output logic [7:0]     data_out,
  output logic           data_latch,
  output logic [NCH-1:0] pwm_cs,
  output logic [15:0]    pwm_wdata,
  output logic           pwm_we,
  output logic           busy
);

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_ADDR_OK = 2'd1,
    F_BYTE1   = 2'd2
  } frame_state_t;

  typedef enum logic {
    S_WAIT  = 1'b0,
    S_SWEEP = 1'b1
  } sweep_state_t;

  localparam logic [2:0] LAST_IDX = 3'(NCH - 1);

  frame_state_t frame_state_reg;
  sweep_state_t sweep_state_reg;

  logic [15:0]    shadow_reg [NCH];
  logic [NCH-1:0] dirty_reg;
  logic [NCH-1:0] commit_reg;
  logic [2:0]     idx_reg;

  logic           is_write_reg;
  logic [2:0]     ch_reg;
  logic           bcast_reg;
  logic [7:0]     low_reg;
  logic [15:0]    snap_reg;

  logic [15:0]    rd_word;
  logic           bcast_dec;
  logic           wr_commit;
  logic [NCH-1:0] wr_hit;

  logic           sweep_go;
  logic [2:0]     sweep_idx;
  logic [NCH-1:0] sweep_src;
  logic [NCH-1:0] sel_next;
  logic [15:0]    wdata_next;

  // Shadow lookup for the address carried by the incoming byte0; invalid addresses read as zero.
  always_comb begin
    rd_word = 16'h0000;
    for (int i = 0; i < NCH; i++) begin
      if (byte_in[4:2] == 3'(i)) begin
        rd_word = shadow_reg[i];
      end
    end
  end

`ifdef PWM_SCHED_BCAST_EN
  assign bcast_dec = (byte_in[4:2] == 3'd7);
`else
  assign bcast_dec = 1'b0;
`endif

  assign wr_commit = (frame_state_reg == F_BYTE1) && byte_valid && !frame_abort && is_write_reg;

  // Frame decoder and readback path.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      frame_state_reg <= F_IDLE;
      is_write_reg    <= 1'b0;
      ch_reg          <= 3'd0;
      bcast_reg       <= 1'b0;
      low_reg         <= 8'h00;
      snap_reg        <= 16'h0000;
      data_out        <= 8'h00;
      data_latch      <= 1'b0;
    end else begin
      data_latch <= 1'b0;
      if (frame_abort) begin
        frame_state_reg <= F_IDLE;
      end else if (byte_valid) begin
        case (frame_state_reg)
          F_IDLE: begin
            is_write_reg    <= byte_in[7];
            ch_reg          <= byte_in[4:2];
            bcast_reg       <= bcast_dec;
            snap_reg        <= rd_word;
            frame_state_reg <= F_ADDR_OK;
            if (!byte_in[7]) begin
              data_out   <= rd_word[7:0];
              data_latch <= 1'b1;
            end
          end
          F_ADDR_OK: begin
            frame_state_reg <= F_BYTE1;
            if (is_write_reg) begin
              low_reg <= byte_in;
            end else begin
              data_out   <= snap_reg[15:8];
              data_latch <= 1'b1;
            end
          end
          F_BYTE1: begin
            frame_state_reg <= F_IDLE;
            if (!is_write_reg) begin
              data_out   <= 8'h00;
              data_latch <= 1'b1;
            end
          end
          default: frame_state_reg <= F_IDLE;
        endcase
      end
    end
  end

  // Per-channel shadow storage; broadcast writes hit every channel at once.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign wr_hit[gi] = wr_commit && (bcast_reg || (ch_reg == 3'(gi)));

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        shadow_reg[gi] <= 16'h0000;
      end else if (wr_hit[gi]) begin
        shadow_reg[gi] <= {byte_in, low_reg};
      end
    end
  end

  // Index whose bus cycle is registered at this edge. Index 0 is issued on the wrap edge
  // itself, so it takes its commit bit straight from dirty rather than from commit_reg.
  always_comb begin
    sweep_go  = 1'b0;
    sweep_idx = 3'd0;
    sweep_src = commit_reg;
    if (sweep_state_reg == S_WAIT) begin
      if (counter_wrap) begin
        sweep_go  = 1'b1;
        sweep_src = dirty_reg;
      end
    end else if (idx_reg != LAST_IDX) begin
      sweep_go  = 1'b1;
      sweep_idx = idx_reg + 3'd1;
    end
  end

  always_comb begin
    sel_next   = '0;
    wdata_next = 16'h0000;
    for (int i = 0; i < NCH; i++) begin
      if (sweep_go && sweep_src[i] && (sweep_idx == 3'(i))) begin
        sel_next[i] = 1'b1;
        wdata_next  = shadow_reg[i];
      end
    end
  end

  // A write landing on the same edge as its commit keeps dirty set: set wins over clear.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      dirty_reg <= '0;
    end else begin
      dirty_reg <= (dirty_reg & ~sel_next) | wr_hit;
    end
  end

  // Commit sweep FSM with registered config-bus outputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sweep_state_reg <= S_WAIT;
      idx_reg         <= 3'd0;
      commit_reg      <= '0;
      busy            <= 1'b0;
      pwm_we          <= 1'b0;
      pwm_cs          <= '0;
      pwm_wdata       <= 16'h0000;
    end else begin
      pwm_we    <= |sel_next;
      pwm_cs    <= sel_next;
      pwm_wdata <= wdata_next;
      case (sweep_state_reg)
        S_WAIT: begin
          if (counter_wrap) begin
            commit_reg      <= dirty_reg;
            idx_reg         <= 3'd0;
            busy            <= 1'b1;
            sweep_state_reg <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          if (idx_reg == LAST_IDX) begin
            busy            <= 1'b0;
            sweep_state_reg <= S_WAIT;
          end else begin
            idx_reg <= idx_reg + 3'd1;
          end
        end
        default: sweep_state_reg <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_update_sched.sv
// Directed bench for pwm_update_sched: frame decode, readback, commit sweeps and collisions.
module tb_pwm_update_sched;

  localparam int NCH = 7;

  logic           sys_clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     byte_in = 8'h00;
  logic           byte_valid = 1'b0;
  logic           frame_abort = 1'b0;
  logic           counter_wrap = 1'b0;
  logic [7:0]     data_out;
  logic           data_latch;
  logic [NCH-1:0] pwm_cs;
  logic [15:0]    pwm_wdata;
  logic           pwm_we;
  logic           busy;

  pwm_update_sched #(.NCH(NCH)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .frame_abort  (frame_abort),
    .counter_wrap (counter_wrap),
    .data_out     (data_out),
    .data_latch   (data_latch),
    .pwm_cs       (pwm_cs),
    .pwm_wdata    (pwm_wdata),
    .pwm_we       (pwm_we),
    .busy         (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [NCH-1:0] we_cs_q[$];
  logic [15:0]    we_data_q[$];
  int             we_cyc_q[$];
  logic [7:0]     latch_q[$];
  int             latch_cyc_q[$];
  int             busy_cnt = 0;
  int             idle_viol = 0;
  int             wrap_cyc = 0;
  int             strobe_cyc = 0;

  always @(negedge sys_clk) begin
    if (pwm_we) begin
      we_cs_q.push_back(pwm_cs);
      we_data_q.push_back(pwm_wdata);
      we_cyc_q.push_back(cyc);
    end else if (pwm_cs != '0 || pwm_wdata != 16'h0000) begin
      idle_viol++;
    end
    if (data_latch) begin
      latch_q.push_back(data_out);
      latch_cyc_q.push_back(cyc);
    end
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clear_logs();
    we_cs_q.delete();
    we_data_q.delete();
    we_cyc_q.delete();
    latch_q.delete();
    latch_cyc_q.delete();
    busy_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge sys_clk);
    #1;
    byte_in    = b;
    byte_valid = 1'b1;
    strobe_cyc = cyc;
    @(posedge sys_clk);
    #1;
    byte_valid = 1'b0;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic pulse_wrap(input bit rec);
    @(posedge sys_clk);
    #1;
    counter_wrap = 1'b1;
    if (rec) wrap_cyc = cyc;
    @(posedge sys_clk);
    #1;
    counter_wrap = 1'b0;
  endtask

  // Checks a sweep that should have produced exactly one bus write.
  task automatic check_single(input string tag, input logic [NCH-1:0] cs,
                              input logic [15:0] data, input int slot);
    check({tag, "_count"}, we_cs_q.size(), 1);
    if (we_cs_q.size() > 0) begin
      check({tag, "_cs"}, 32'(we_cs_q[0]), 32'(cs));
      check({tag, "_wdata"}, 32'(we_data_q[0]), 32'(data));
      check({tag, "_slot"}, we_cyc_q[0] - wrap_cyc - 1, slot);
    end
  endtask

  task automatic check_read(input string tag, input logic [7:0] lo, input logic [7:0] hi);
    check({tag, "_latches"}, latch_q.size(), 3);
    if (latch_q.size() == 3) begin
      check({tag, "_lo"}, 32'(latch_q[0]), 32'(lo));
      check({tag, "_hi"}, 32'(latch_q[1]), 32'(hi));
      check({tag, "_tail"}, 32'(latch_q[2]), 32'h00);
      check({tag, "_lat"}, latch_cyc_q[2] - strobe_cyc, 1);
    end
  endtask

  initial begin
    idle(3);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_pwm_we", 32'(pwm_we), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    idle(2);
    check("rst_cs_wdata", {pwm_wdata, 9'd0, pwm_cs}, 32'h0);
    check("rst_latch", 32'(data_latch), 0);

    // ch2 = 0x1234, committed in slot 2.
    clear_logs();
    send_frame(8'h88, 8'h34, 8'h12);
    check("wr2_no_early_we", we_cs_q.size(), 0);
    pulse_wrap(1'b1);
    idle(10);
    check_single("ch2", 7'b0000100, 16'h1234, 2);
    check("ch2_busy_len", busy_cnt, NCH);

    // Dirty was cleared: the next wrap is a silent sweep.
    clear_logs();
    pulse_wrap(1'b1);
    idle(10);
    check("silent_count", we_cs_q.size(), 0);
    check("silent_busy_len", busy_cnt, NCH);

    // Readback of ch2.
    clear_logs();
    send_frame(8'h08, 8'h00, 8'h00);
    check_read("rd2", 8'h34, 8'h12);
    check("rd2_first_lat", latch_cyc_q.size() > 0 ? latch_cyc_q[0] - (strobe_cyc - 6) : -1, 1);

    // Aborted ch5 frame followed by a full ch5 = 0x00FF write.
    clear_logs();
    send_byte(8'h94);
    send_byte(8'hAA);
    @(posedge sys_clk);
    #1;
    frame_abort = 1'b1;
    @(posedge sys_clk);
    #1;
    frame_abort = 1'b0;
    send_frame(8'h94, 8'hFF, 8'h00);
    send_frame(8'h14, 8'h00, 8'h00);
    check_read("rd5", 8'hFF, 8'h00);
    clear_logs();
    pulse_wrap(1'b1);
    idle(10);
    check_single("ch5", 7'b0100000, 16'h00FF, 5);

    // ch0 write landing on ch0's sweep slot: old value goes out, new one next wrap.
    clear_logs();
    send_frame(8'h80, 8'h11, 8'h11);
    send_byte(8'h80);
    send_byte(8'h22);
    @(posedge sys_clk);
    #1;
    byte_in      = 8'h22;
    byte_valid   = 1'b1;
    counter_wrap = 1'b1;
    wrap_cyc     = cyc;
    @(posedge sys_clk);
    #1;
    byte_valid   = 1'b0;
    counter_wrap = 1'b0;
    idle(10);
    check_single("col_old", 7'b0000001, 16'h1111, 0);
    clear_logs();
    pulse_wrap(1'b1);
    idle(10);
    check_single("col_new", 7'b0000001, 16'h2222, 0);

    // Wrap during a sweep is ignored: one sweep of NCH cycles only.
    clear_logs();
    send_frame(8'h8C, 8'h33, 8'h33);
    pulse_wrap(1'b1);
    idle(1);
    pulse_wrap(1'b0);
    idle(12);
    check_single("midwrap", 7'b0001000, 16'h3333, 3);
    check("midwrap_busy_len", busy_cnt, NCH);
    check("midwrap_busy_end", 32'(busy), 0);

    // Address 7: broadcast when enabled, discarded otherwise; reads give zeros.
    clear_logs();
    send_frame(8'h9C, 8'hCD, 8'hAB);
    pulse_wrap(1'b1);
    idle(10);
`ifdef PWM_SCHED_BCAST_EN
    check("bcast_count", we_cs_q.size(), NCH);
    for (int k = 0; k < NCH; k++) begin
      if (k < we_cs_q.size()) begin
        check($sformatf("bcast_cs%0d", k), 32'(we_cs_q[k]), 32'(1) << k);
        check($sformatf("bcast_wd%0d", k), 32'(we_data_q[k]), 32'hABCD);
        check($sformatf("bcast_slot%0d", k), we_cyc_q[k] - wrap_cyc - 1, k);
      end
    end
`else
    check("addr7_no_we", we_cs_q.size(), 0);
`endif
    clear_logs();
    send_frame(8'h1C, 8'h00, 8'h00);
    check_read("rd7", 8'h00, 8'h00);

    check("idle_bus_zero", idle_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
